if_branch_predictor: RTL and testbench



---
 rtl/if_branch_predictor.sv | 179 +++++++++++++++++
 tb/tb_if_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_branch_predictor.sv
// if_branch_predictor: fetch-stage dynamic branch predictor.
// Direct-mapped table of {valid, tag, 2-bit saturating counter, target}.
// Produces a combinational taken/target prediction for IF_PC, and a
// combinational mispredict/redirect for the branch resolved in EX.
// Resolutions are captured into a pending-update register and committed
// one cycle later. A bypass lets fetch see the post-commit entry in the
// meantime.
//
// Handshake: EX_Branch_Valid is a single-cycle qualifier with no
// backpressure. Every cycle in which it is high is exactly one resolved
// branch, and all EX_* inputs are sampled in that cycle. The predictor
// is always ready.
module if_branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 30 - IDX_BITS,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IF_PC,
  input  logic             branch_predictor_enable,
  output logic             IF_Pred_Taken,
  output logic [31:0]      IF_Pred_Target,
  input  logic             EX_Branch_Valid,
  input  logic [31:0]      EX_PC,
  input  logic             EX_Taken,
  input  logic [31:0]      EX_Target,
  input  logic             EX_Pred_Taken,
  input  logic [31:0]      EX_Pred_Target,
  output logic             EX_Mispredict,
  output logic [31:0]      EX_Redirect_PC,
  input  logic             Stat_Clear,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Mispredict_Count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Table storage
  logic                valid_mem  [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [1:0]          cnt_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];

  // Pending update register
  logic                u_valid;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                u_taken;
  logic [31:0]         u_target;

  // Post-commit value of entry u_idx
  logic                c_valid;
  logic [TAG_BITS-1:0] c_tag;
  logic [1:0]          c_cnt;
  logic [31:0]         c_target;
  logic                c_hit;

  // Lookup signals
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [31:0]         if_pc_plus4;
  logic                l_valid;
  logic [TAG_BITS-1:0] l_tag;
  logic [1:0]          l_cnt;
  logic [31:0]         l_target;
  logic                l_hit;

  // EX-side signals
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;

  assign if_idx      = IF_PC[IDX_BITS+1:2];
  assign if_tag      = IF_PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign if_pc_plus4 = IF_PC + 32'd4;
  assign ex_idx      = EX_PC[IDX_BITS+1:2];
  assign ex_tag      = EX_PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Capture each resolved branch for commit in the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_valid  <= 1'b0;
      u_idx    <= '0;
      u_tag    <= '0;
      u_taken  <= 1'b0;
      u_target <= '0;
    end else begin
      u_valid <= EX_Branch_Valid;
      if (EX_Branch_Valid) begin
        u_idx    <= ex_idx;
        u_tag    <= ex_tag;
        u_taken  <= EX_Taken;
        u_target <= EX_Target;
      end
    end
  end

  // Read-modify-write: compute the post-commit entry for u_idx
  always_comb begin
    c_valid  = valid_mem[u_idx];
    c_tag    = tag_mem[u_idx];
    c_cnt    = cnt_mem[u_idx];
    c_target = target_mem[u_idx];
    c_hit    = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
    if (c_hit) begin
      if (u_taken) begin
        if (cnt_mem[u_idx] != 2'b11) c_cnt = cnt_mem[u_idx] + 2'd1;
        c_target = u_target;
      end else begin
        if (cnt_mem[u_idx] != 2'b00) c_cnt = cnt_mem[u_idx] - 2'd1;
      end
    end else if (u_taken) begin
      c_valid  = 1'b1;
      c_tag    = u_tag;
      c_cnt    = 2'b10;
      c_target = u_target;
    end
  end

  // Commit the pending update into the table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        cnt_mem[i]    <= 2'b01;
        target_mem[i] <= '0;
      end
    end else if (u_valid) begin
      valid_mem[u_idx]  <= c_valid;
      tag_mem[u_idx]    <= c_tag;
      cnt_mem[u_idx]    <= c_cnt;
      target_mem[u_idx] <= c_target;
    end
  end

  // Fetch lookup, bypassing the pending commit when it targets the same index
  always_comb begin
    if (u_valid && (if_idx == u_idx)) begin
      l_valid  = c_valid;
      l_tag    = c_tag;
      l_cnt    = c_cnt;
      l_target = c_target;
    end else begin
      l_valid  = valid_mem[if_idx];
      l_tag    = tag_mem[if_idx];
      l_cnt    = cnt_mem[if_idx];
      l_target = target_mem[if_idx];
    end
    l_hit          = l_valid && (l_tag == if_tag);
    IF_Pred_Taken  = branch_predictor_enable && l_hit && l_cnt[1];
    IF_Pred_Target = IF_Pred_Taken ? l_target : if_pc_plus4;
  end

  // Mispredict detection and correct next PC for the EX branch
  always_comb begin
    EX_Mispredict  = EX_Branch_Valid &&
                     ((EX_Taken != EX_Pred_Taken) ||
                      (EX_Taken && (EX_Pred_Target != EX_Target)));
    EX_Redirect_PC = EX_Taken ? EX_Target : (EX_PC + 32'd4);
  end

  // Saturating statistics counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else if (Stat_Clear) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      if (EX_Branch_Valid && (Branch_Count != '1))
        Branch_Count <= Branch_Count + 1'b1;
      if (EX_Mispredict && (Mispredict_Count != '1))
        Mispredict_Count <= Mispredict_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_branch_predictor.sv
// tb_if_branch_predictor: scoreboard bench for if_branch_predictor.
// A driver issues one cycle of stimulus, asks a behavioural table model
// for the expected outputs, and queues them. A monitor on the falling
// edge pops and compares.
module tb_if_branch_predictor;

  localparam int IDX_BITS = 4;
  localparam int CNT_W    = 4;
  localparam int ENTRIES  = 16;
  localparam int CNT_MAX  = 15;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [31:0] redir;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] if_pc = '0;
  logic        en = 1'b0;
  logic        bv = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        stat_clear = 1'b0;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  if_branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .IF_PC                   (if_pc),
    .branch_predictor_enable (en),
    .IF_Pred_Taken           (if_pred_taken),
    .IF_Pred_Target          (if_pred_target),
    .EX_Branch_Valid         (bv),
    .EX_PC                   (ex_pc),
    .EX_Taken                (ex_taken),
    .EX_Target               (ex_target),
    .EX_Pred_Taken           (ex_pred_taken),
    .EX_Pred_Target          (ex_pred_target),
    .EX_Mispredict           (ex_mispredict),
    .EX_Redirect_PC          (ex_redirect_pc),
    .Stat_Clear              (stat_clear),
    .Branch_Count            (branch_count),
    .Mispredict_Count        (mispredict_count)
  );

  // ---------------- reference model ----------------
  // Holds the newest architectural view of the table: every resolution
  // seen so far is applied, so a lookup in the next cycle sees it.
  bit          m_valid [ENTRIES];
  bit [25:0]   m_tag   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  int          m_bcnt;
  int          m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_cnt[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit [25:0] pc_tag(input logic [31:0] pc);
    return pc[31:6];
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pc, input logic e, input logic v,
                       input logic [31:0] xpc, input logic t, input logic [31:0] xt,
                       input logic pt, input logic [31:0] ptg, input logic clr);
    exp_t x;
    int   fi, xi;
    bit   fhit, xhit;
    @(posedge clk);
    #1;
    if_pc = pc; en = e; bv = v; ex_pc = xpc; ex_taken = t; ex_target = xt;
    ex_pred_taken = pt; ex_pred_target = ptg; stat_clear = clr;
    // expected outputs for this cycle
    fi = pc_idx(pc);
    fhit = m_valid[fi] && (m_tag[fi] == pc_tag(pc));
    x.taken  = e && fhit && (m_cnt[fi] >= 2);
    x.target = x.taken ? m_tgt[fi] : pc + 32'd4;
    x.misp   = v && ((t != pt) || (t && (ptg != xt)));
    x.redir  = t ? xt : xpc + 32'd4;
    x.bcnt   = CNT_W'(m_bcnt);
    x.mcnt   = CNT_W'(m_mcnt);
    exp_q.push_back(x);
    // apply this cycle's resolution and statistics to the model
    if (v) begin
      xi = pc_idx(xpc);
      xhit = m_valid[xi] && (m_tag[xi] == pc_tag(xpc));
      if (xhit && t) begin
        m_cnt[xi] = (m_cnt[xi] + 1 > 3) ? 3 : m_cnt[xi] + 1;
        m_tgt[xi] = xt;
      end else if (xhit) begin
        m_cnt[xi] = (m_cnt[xi] - 1 < 0) ? 0 : m_cnt[xi] - 1;
      end else if (t) begin
        m_valid[xi] = 1'b1;
        m_tag[xi]   = pc_tag(xpc);
        m_cnt[xi]   = 2;
        m_tgt[xi]   = xt;
      end
    end
    if (clr) begin
      m_bcnt = 0;
      m_mcnt = 0;
    end else begin
      if (v && m_bcnt < CNT_MAX) m_bcnt++;
      if (x.misp && m_mcnt < CNT_MAX) m_mcnt++;
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic e);
    drive(pc, e, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] xpc, input logic t,
                         input logic [31:0] xt, input logic pt, input logic [31:0] ptg);
    drive(pc, 1'b1, 1'b1, xpc, t, xt, pt, ptg, 1'b0);
  endtask

  // Reset asserted one cycle after the last drive, i.e. while that
  // resolution is still pending commit.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bv = 1'b0; stat_clear = 1'b0; en = 1'b0;
    model_reset();
    #10;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (if_pred_taken !== x.taken) begin
        errors++;
        $display("FAIL pred_taken pc=%h got %0b exp %0b", if_pc, if_pred_taken, x.taken);
      end
      checks++;
      if (if_pred_target !== x.target) begin
        errors++;
        $display("FAIL pred_target pc=%h got %h exp %h", if_pc, if_pred_target, x.target);
      end
      checks++;
      if (ex_mispredict !== x.misp) begin
        errors++;
        $display("FAIL mispredict ex_pc=%h got %0b exp %0b", ex_pc, ex_mispredict, x.misp);
      end
      if (x.misp) begin
        checks++;
        if (ex_redirect_pc !== x.redir) begin
          errors++;
          $display("FAIL redirect ex_pc=%h got %h exp %h", ex_pc, ex_redirect_pc, x.redir);
        end
      end
      checks++;
      if (branch_count !== x.bcnt) begin
        errors++;
        $display("FAIL branch_count got %0d exp %0d", branch_count, x.bcnt);
      end
      checks++;
      if (mispredict_count !== x.mcnt) begin
        errors++;
        $display("FAIL mispredict_count got %0d exp %0d", mispredict_count, x.mcnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rpc, rxpc, rt;
    model_reset();
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;

    // reset state
    lookup(32'h100, 1'b1);
    // first resolution: taken to 0x80, predicted not taken
    resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    // bypass: next cycle sees the new entry
    lookup(32'h100, 1'b1);
    lookup(32'h100, 1'b1);
    // two not-taken: counter 2 -> 1 -> 0
    resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    lookup(32'h100, 1'b1);
    resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    // strengthen back to taken, then check saturation at 3
    for (int i = 0; i < 5; i++) resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h100, 1'b1);
    // alias 0x140 onto the same index
    resolve(32'h100, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    lookup(32'h100, 1'b1);
    lookup(32'h140, 1'b1);
    // stall masks prediction only
    lookup(32'h140, 1'b0);
    lookup(32'h140, 1'b1);
    // taken with wrong predicted target
    resolve(32'h140, 32'h140, 1'b1, 32'h300, 1'b1, 32'h200);
    lookup(32'h140, 1'b1);

    // statistics: clear, saturate, clear-with-increment
    drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < CNT_MAX + 2; i++)
      resolve(32'h0, 32'h40 + 32'(i) * 4, 1'b0, 32'h0, 1'b1, 32'h10);
    lookup(32'h0, 1'b1);
    drive(32'h0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1);
    lookup(32'h0, 1'b1);
    lookup(32'h0, 1'b1);

    // reset while an update is pending
    resolve(32'h100, 32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
    do_reset();
    lookup(32'h180, 1'b1);
    lookup(32'h180, 1'b1);

    // randomized traffic over a small aliasing PC set
    for (int i = 0; i < 600; i++) begin
      rpc  = 32'h1000 + 32'($urandom_range(0, 23)) * 4 + ($urandom_range(0, 1) ? 32'h40 : 32'h0);
      rxpc = 32'h1000 + 32'($urandom_range(0, 23)) * 4 + ($urandom_range(0, 1) ? 32'h40 : 32'h0);
      rt   = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
      drive(rpc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0), rxpc,
            1'($urandom_range(0, 1)), rt, 1'($urandom_range(0, 1)),
            32'h2000 + 32'($urandom_range(0, 3)) * 4, ($urandom_range(0, 60) == 0));
      if (i == 300) begin
        resolve(rpc, rxpc, 1'b1, rt, 1'b0, 32'h0);
        do_reset();
      end
    end

    // drain the scoreboard with a bounded wait
    @(posedge clk);
    #1;
    bv = 1'b0; stat_clear = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
